// File: rtl/fixed_point_iterative_divider.sv
// Multi-cycle fixed-point divider, one restoring step per clock.
// Val/rdy stream in and out, one transaction in flight.
module fixed_point_iterative_divider #(
    parameter int n    = 6,
    parameter int d    = 0,
    parameter bit sign = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         recv_val,
    output logic         recv_rdy,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic         send_val,
    input  logic         send_rdy,
    output logic [n-1:0] c
);

    localparam int W  = n + d;
    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(W);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_dvd;
    logic [n-1:0]  r_rem;
    logic [n-1:0]  r_b;
    logic [n-1:0]  r_c;
    logic          r_neg;

    logic [n-1:0]  w_abs_a;
    logic [n-1:0]  w_abs_b;
    logic          w_neg;
    logic [W-1:0]  w_dvd_init;
    logic [n:0]    w_sh;
    logic          w_ge;
    logic [n-1:0]  w_diff;
    logic [W-1:0]  w_q;
    logic [n-1:0]  w_res;

    // Magnitudes are n-bit unsigned, so -2^(n-1) maps cleanly to 2^(n-1)
    always_comb begin
        w_abs_a = (sign && a[n-1]) ? -a : a;
        w_abs_b = (sign && b[n-1]) ? -b : b;
        w_neg   = sign && (a[n-1] ^ b[n-1]);
        w_dvd_init = '0;
        w_dvd_init[W-1 -: n] = w_abs_a;
    end

    always_comb begin
        w_sh   = {r_rem, r_dvd[W-1]};
        w_ge   = (w_sh >= {1'b0, r_b});
        w_diff = w_sh[n-1:0] - r_b;
        w_q    = {r_dvd[W-2:0], w_ge};
        w_res  = r_neg ? -w_q[n-1:0] : w_q[n-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (recv_val) w_next = CALC;
            CALC:    if (r_cnt == CNT_ONE) w_next = DONE;
            DONE:    if (send_rdy) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_dvd <= '0;
            r_rem <= '0;
            r_b   <= '0;
            r_neg <= 1'b0;
            r_c   <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (recv_val) begin
                        r_cnt <= CNT_INIT;
                        r_dvd <= w_dvd_init;
                        r_rem <= '0;
                        r_b   <= w_abs_b;
                        r_neg <= w_neg;
                    end
                end
                CALC: begin
                    r_rem <= w_ge ? w_diff : w_sh[n-1:0];
                    r_dvd <= w_q;
                    r_cnt <= r_cnt - CNT_ONE;
                    if (r_cnt == CNT_ONE) r_c <= w_res;
                end
                default: ;
            endcase
        end
    end

    assign recv_rdy = (r_state == IDLE);
    assign send_val = (r_state == DONE);
    assign c        = r_c;

endmodule
